// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types for the shift-and-add multiply-accumulate unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier
//  Description : Sequential shift-and-add MAC, product = A*B + C, one
//                multiplier bit per clock with a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic [N-1:0]   addend,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy,
    output logic           overflow
);

    localparam int           CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q,    state_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [N-1:0]     a_q,        a_d;
    logic [N-1:0]     b_q,        b_d;
    logic [2*N-1:0]   acc_q,      acc_d;
    logic [2*N-1:0]   product_q,  product_d;
    logic             done_q,     done_d;
    logic             overflow_q, overflow_d;
    logic [2*N-1:0]   acc_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            product_q  <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            product_q  <= product_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        // Partial product for the current bit; the 2N-bit sum cannot carry out.
        acc_step   = acc_q + (b_q[0] ? ({{N{1'b0}}, a_q} << count_q) : '0);
        state_d    = state_q;
        count_d    = count_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        product_d  = product_q;
        done_d     = done_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d        = multiplicand;
                    b_d        = multiplier;
                    acc_d      = {{N{1'b0}}, addend};
                    count_d    = '0;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_step;
                b_d     = b_q >> 1;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    count_d    = '0;
                    product_d  = acc_step;
                    overflow_d = |acc_step[2*N-1:N];
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign product  = product_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule : shift_add_multiplier
`default_nettype wire
